// File: rtl/comparador_serie_ctrl.sv
// ============================================================================
// Module   : comparador_serie_ctrl
// Purpose  : Bit-serial (MSB first) equality comparator sequencer with
//            start/done handshake. Define COMPARADOR_FIN_TEMPRANO_EN to end
//            the walk as soon as a mismatching bit is found.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module comparador_serie_ctrl #(
    parameter int WIDTH = 4,
    parameter int IDXW  = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic            cancelar,
    output logic            listo,
    output logic            ocupado,
    output logic [IDXW-1:0] bit_idx,
    output logic            done,
    output logic            igual
);

`ifdef COMPARADOR_FIN_TEMPRANO_EN
    localparam bit C_FIN_TEMPRANO = 1'b1;
`else
    localparam bit C_FIN_TEMPRANO = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARA = 2'd1,
        FIN     = 2'd2
    } state_t;

    state_t           state_q,   state_d;
    logic [WIDTH-1:0] a_q,       a_d;
    logic [WIDTH-1:0] b_q,       b_d;
    logic             hab_q,     hab_d;
    logic             listo_q,   listo_d;
    logic             ocupado_q, ocupado_d;
    logic [IDXW-1:0]  bit_idx_q, bit_idx_d;
    logic             done_q,    done_d;
    logic             igual_q,   igual_d;
    logic             w_bit_eq;

    // Mux out the current bit with a compare loop so the index width need
    // not match log2(WIDTH).
    always_comb begin
        w_bit_eq = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            if (bit_idx_q == IDXW'(i)) begin
                w_bit_eq = a_q[i] ~^ b_q[i];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        hab_d     = hab_q;
        listo_d   = listo_q;
        ocupado_d = ocupado_q;
        bit_idx_d = bit_idx_q;
        done_d    = 1'b0;
        igual_d   = igual_q;

        case (state_q)
            IDLE: begin
                listo_d = 1'b1;
                if (start) begin
                    a_d       = a;
                    b_d       = b;
                    hab_d     = 1'b1;
                    bit_idx_d = IDXW'(WIDTH - 1);
                    igual_d   = 1'b0;
                    listo_d   = 1'b0;
                    ocupado_d = 1'b1;
                    state_d   = COMPARA;
                end
            end
            COMPARA: begin
                if (cancelar) begin
                    listo_d   = 1'b1;
                    ocupado_d = 1'b0;
                    bit_idx_d = '0;
                    state_d   = IDLE;
                end else begin
                    hab_d = hab_q & w_bit_eq;
                    if (bit_idx_q == '0 || (C_FIN_TEMPRANO && !hab_d)) begin
                        done_d    = 1'b1;
                        igual_d   = hab_d;
                        ocupado_d = 1'b0;
                        bit_idx_d = '0;
                        state_d   = FIN;
                    end else begin
                        bit_idx_d = bit_idx_q - 1'b1;
                    end
                end
            end
            FIN: begin
                listo_d = 1'b1;
                state_d = IDLE;
            end
            default: begin
                listo_d   = 1'b1;
                ocupado_d = 1'b0;
                bit_idx_d = '0;
                state_d   = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            hab_q     <= 1'b1;
            listo_q   <= 1'b1;
            ocupado_q <= 1'b0;
            bit_idx_q <= '0;
            done_q    <= 1'b0;
            igual_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            hab_q     <= hab_d;
            listo_q   <= listo_d;
            ocupado_q <= ocupado_d;
            bit_idx_q <= bit_idx_d;
            done_q    <= done_d;
            igual_q   <= igual_d;
        end
    end

    assign listo   = listo_q;
    assign ocupado = ocupado_q;
    assign bit_idx = bit_idx_q;
    assign done    = done_q;
    assign igual   = igual_q;

endmodule

`default_nettype wire

// File: tb/tb_comparador_serie_ctrl.sv
// ============================================================================
// Module   : tb_comparador_serie_ctrl
// Purpose  : Self-checking bench for comparador_serie_ctrl (WIDTH=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_comparador_serie_ctrl;

    localparam int WIDTH = 4;
    localparam int IDXW  = 4;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cancelar;
    logic             listo;
    logic             ocupado;
    logic [IDXW-1:0]  bit_idx;
    logic             done;
    logic             igual;

    comparador_serie_ctrl #(.WIDTH(WIDTH), .IDXW(IDXW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a        (a),
        .b        (b),
        .cancelar (cancelar),
        .listo    (listo),
        .ocupado  (ocupado),
        .bit_idx  (bit_idx),
        .done     (done),
        .igual    (igual)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] va;
        logic [WIDTH-1:0] vb;
        logic             exp_igual;
    } vec_t;

    typedef struct {
        logic igual;
        int   lat;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[8];

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Cycles from the accepting edge until done is seen, counting the
    // cycle right after acceptance as 1.
    function automatic int model_lat(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb);
        int lat;
        lat = WIDTH + 1;
`ifdef COMPARADOR_FIN_TEMPRANO_EN
        for (int k = WIDTH - 1; k >= 0; k--) begin
            if (va[k] != vb[k]) begin
                lat = WIDTH - k + 1;
                break;
            end
        end
`endif
        return lat;
    endfunction

    task automatic run_cmp(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                           input logic exp_eq, input bit chk_idx);
        exp_t e;
        int   cyc;
        bit   seen;
        @(negedge clk);
        a     = va;
        b     = vb;
        start = 1'b1;
        e.igual = exp_eq;
        e.lat   = model_lat(va, vb);
        sb.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
        cyc   = 1;
        seen  = 0;
        while (!seen && cyc <= 20) begin
            if (done) begin
                seen = 1;
            end else begin
                if (chk_idx) begin
                    check($sformatf("bit_idx c%0d", cyc), 32'(bit_idx), 32'(WIDTH - cyc));
                    check($sformatf("ocupado c%0d", cyc), 32'(ocupado), 32'd1);
                end
                @(posedge clk); #1;
                cyc++;
            end
        end
        e = sb.pop_front();
        if (!seen) begin
            check("done timeout", 32'd0, 32'd1);
        end else begin
            check($sformatf("igual %h/%h", va, vb), 32'(igual), 32'(e.igual));
            check($sformatf("latency %h/%h", va, vb), 32'(cyc), 32'(e.lat));
            check("ocupado in FIN", 32'(ocupado), 32'd0);
        end
        @(posedge clk); #1;
        check("listo after FIN", 32'(listo), 32'd1);
        check("done one pulse", 32'(done), 32'd0);
    endtask

    initial begin
        int ndone;

        vecs[0] = '{4'b1011, 4'b1010, 1'b0};
        vecs[1] = '{4'b0000, 4'b1000, 1'b0};
        vecs[2] = '{4'b0110, 4'b0110, 1'b1};
        vecs[3] = '{4'b1111, 4'b1101, 1'b0};
        vecs[4] = '{4'b0000, 4'b0000, 1'b1};
        vecs[5] = '{4'b1001, 4'b0001, 1'b0};
        vecs[6] = '{4'b0101, 4'b0100, 1'b0};
        vecs[7] = '{4'b1111, 4'b1111, 1'b1};

        rst_n = 1'b0; start = 1'b0; cancelar = 1'b0; a = '0; b = '0;
        #12;
        check("rst listo",   32'(listo),   32'd1);
        check("rst ocupado", 32'(ocupado), 32'd0);
        check("rst done",    32'(done),    32'd0);
        check("rst igual",   32'(igual),   32'd0);
        check("rst bit_idx", 32'(bit_idx), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_cmp(4'b1010, 4'b1010, 1'b1, 1'b1);

        for (int i = 0; i < 8; i++) begin
            run_cmp(vecs[i].va, vecs[i].vb, vecs[i].exp_igual, 1'b0);
        end

        // Operand changes and a second start during COMPARA are ignored.
        @(negedge clk);
        a = 4'b1100; b = 4'b1100; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = 4'b0001; b = 4'b1110;
        @(negedge clk);
        start = 1'b1; a = 4'b0011; b = 4'b0000;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        for (int c = 0; c < 10; c++) begin
            if (done) begin
                ndone++;
                check("ignored-start igual", 32'(igual), 32'd1);
            end
            @(negedge clk);
        end
        check("ignored-start done count", 32'(ndone), 32'd1);

        // Cancel in the second COMPARA cycle.
        @(negedge clk);
        a = 4'b0110; b = 4'b0110; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        cancelar = 1'b1;
        @(negedge clk);
        cancelar = 1'b0;
        check("cancel listo",   32'(listo),   32'd1);
        check("cancel ocupado", 32'(ocupado), 32'd0);
        check("cancel igual",   32'(igual),   32'd0);
        ndone = 0;
        for (int c = 0; c < 8; c++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        check("cancel no done", 32'(ndone), 32'd0);
        run_cmp(4'b1111, 4'b1111, 1'b1, 1'b0);

        // start and cancelar together in IDLE: start wins.
        @(negedge clk);
        a = 4'b0011; b = 4'b0011; start = 1'b1; cancelar = 1'b1;
        @(negedge clk);
        start = 1'b0; cancelar = 1'b0;
        check("start beats cancel", 32'(ocupado), 32'd1);
        repeat (8) @(negedge clk);

        // Asynchronous reset in the third COMPARA cycle.
        a = 4'b1001; b = 4'b1001; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst ocupado", 32'(ocupado), 32'd0);
        check("async rst listo",   32'(listo),   32'd1);
        check("async rst bit_idx", 32'(bit_idx), 32'd0);
        check("async rst igual",   32'(igual),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int c = 0; c < 8; c++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        check("no done after rst", 32'(ndone), 32'd0);
        check("idle after rst", 32'(listo), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
